ama_riscv_hpm_unit: RTL and testbench



---
 rtl/ama_riscv_hpm_unit_pkg.sv | 27 ++
 rtl/ama_riscv_hpm_cnt.sv | 81 ++++++++
 rtl/ama_riscv_hpm_unit.sv | 112 +++++++++++
 tb/tb_ama_riscv_hpm_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ama_riscv_hpm_unit_pkg.sv
// Shared HPM constants, access bundle type and parameter legality helper.
// No logic of its own; latency and backpressure belong to the modules that import it.
package ama_riscv_hpm_unit_pkg;

   typedef logic [11:0] csr_addr_t;

   localparam csr_addr_t CSR_MHPMCOUNTER_BASE   = 12'hB03;
   localparam csr_addr_t CSR_MHPMCOUNTER_H_BASE = 12'hB83;
   localparam csr_addr_t CSR_MHPMEVENT_BASE     = 12'h323;
   localparam csr_addr_t CSR_MCOUNTINHIBIT      = 12'h320;
   localparam csr_addr_t CSR_MHPMOVF            = 12'h7C0;
   localparam int unsigned MHPM_IDX_L = 3;

   typedef struct packed {
      logic        en;
      logic        we;
      csr_addr_t   addr;
      logic [31:0] wdata;
   } hpm_acc_t;

   function automatic bit hpm_params_legal(int num_cnt, int cnt_width, int num_events);
      return (num_cnt >= 1) && (num_cnt <= 29) &&
             (cnt_width >= 33) && (cnt_width <= 64) &&
             (num_events >= 1) && (num_events <= 32);
   endfunction

endpackage

// File: rtl/ama_riscv_hpm_cnt.sv
// One HPM counter slice: event mask, popcount increment, counter with half writes, sticky ovf.
// State updates on the next edge; o_ovf_next is combinational; no backpressure (always accepts).
module ama_riscv_hpm_cnt
   import ama_riscv_hpm_unit_pkg::*;
#(
   parameter int unsigned CNT_WIDTH  = 48,
   parameter int unsigned NUM_EVENTS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_EVENTS-1:0] i_events,
   input  logic                  i_inhibit,
   input  logic                  i_wr_lo,
   input  logic                  i_wr_hi,
   input  logic                  i_wr_mask,
   input  logic [31:0]           i_wdata,
   input  logic                  i_ovf_clr,
   output logic [CNT_WIDTH-1:0]  o_cnt,
   output logic [NUM_EVENTS-1:0] o_mask,
   output logic                  o_ovf,
   output logic                  o_ovf_next
);

   localparam int unsigned INC_W = $clog2(NUM_EVENTS + 1);

   logic [NUM_EVENTS-1:0] r_mask;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic                  r_ovf;
   logic [NUM_EVENTS-1:0] w_hits;
   logic [INC_W-1:0]      w_inc;
   logic [CNT_WIDTH:0]    w_sum;
   logic [CNT_WIDTH-1:0]  w_cnt_next;
   logic                  w_wrap;

   assign w_hits = i_events & r_mask;

   always_comb begin
      w_inc = '0;
      for (int k = 0; k < NUM_EVENTS; k++) begin
         w_inc = w_inc + INC_W'(w_hits[k]);
      end
   end

   // Carry out of the extended sum is the wrap indication
   assign w_sum = {1'b0, r_cnt} + (CNT_WIDTH+1)'(w_inc);

   always_comb begin
      w_cnt_next = r_cnt;
      w_wrap     = 1'b0;
      if (i_wr_lo) begin
         w_cnt_next[31:0] = i_wdata;
      end else if (i_wr_hi) begin
         w_cnt_next[CNT_WIDTH-1:32] = i_wdata[CNT_WIDTH-33:0];
      end else if (!i_inhibit) begin
         w_cnt_next = w_sum[CNT_WIDTH-1:0];
         w_wrap     = w_sum[CNT_WIDTH];
      end
   end

   // A fresh wrap beats a same-cycle clear
   assign o_ovf_next = w_wrap | (r_ovf & ~i_ovf_clr);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_mask <= '0;
         r_ovf  <= 1'b0;
      end else begin
         r_cnt <= w_cnt_next;
         r_ovf <= o_ovf_next;
         if (i_wr_mask) begin
            r_mask <= i_wdata[NUM_EVENTS-1:0];
         end
      end
   end

   assign o_cnt  = r_cnt;
   assign o_mask = r_mask;
   assign o_ovf  = r_ovf;

endmodule

// File: rtl/ama_riscv_hpm_unit.sv
// HPM bank: CSR decode, mcountinhibit, W1C overflow status, read mux, irq; optional AMA_RISCV_HPM_FREEZE_ON_OVF_EN.
// Reads combinational, writes visible next cycle, irq registered; no backpressure (every access accepted).
module ama_riscv_hpm_unit
   import ama_riscv_hpm_unit_pkg::*;
#(
   parameter int unsigned NUM_CNT    = 6,
   parameter int unsigned CNT_WIDTH  = 48,
   parameter int unsigned NUM_EVENTS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_acc_en,
   input  logic                  i_acc_we,
   input  logic [11:0]           i_acc_addr,
   input  logic [31:0]           i_acc_wdata,
   output logic [31:0]           o_acc_rdata,
   output logic                  o_acc_hit,
   input  logic [NUM_EVENTS-1:0] i_events,
   output logic                  o_ovf_irq
);

   if (!hpm_params_legal(NUM_CNT, CNT_WIDTH, NUM_EVENTS)) begin : g_bad_params
      $error("ama_riscv_hpm_unit: illegal NUM_CNT/CNT_WIDTH/NUM_EVENTS");
   end

   hpm_acc_t              w_acc;
   logic                  w_wr;
   logic [NUM_CNT-1:0]    w_hit_lo;
   logic [NUM_CNT-1:0]    w_hit_hi;
   logic [NUM_CNT-1:0]    w_hit_mask;
   logic                  w_hit_inh;
   logic                  w_hit_ovf;
   logic [NUM_CNT-1:0]    r_inhibit;
   logic [NUM_CNT-1:0]    w_inh_eff;
   logic [NUM_CNT-1:0]    w_ovf;
   logic [NUM_CNT-1:0]    w_ovf_next;
   logic [CNT_WIDTH-1:0]  w_cnt  [NUM_CNT];
   logic [NUM_EVENTS-1:0] w_mask [NUM_CNT];
   logic [63:0]           w_cnt_ext [NUM_CNT];
   logic [31:0]           w_rdata;
   logic                  r_ovf_irq;

   assign w_acc = '{en: i_acc_en, we: i_acc_we, addr: i_acc_addr, wdata: i_acc_wdata};
   assign w_wr  = w_acc.en & w_acc.we;

   assign w_hit_inh = w_acc.en && (w_acc.addr == CSR_MCOUNTINHIBIT);
   assign w_hit_ovf = w_acc.en && (w_acc.addr == CSR_MHPMOVF);

`ifdef AMA_RISCV_HPM_FREEZE_ON_OVF_EN
   assign w_inh_eff = r_inhibit | {NUM_CNT{|w_ovf}};
`else
   assign w_inh_eff = r_inhibit;
`endif

   for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
      localparam csr_addr_t A_LO   = CSR_MHPMCOUNTER_BASE   + csr_addr_t'(i);
      localparam csr_addr_t A_HI   = CSR_MHPMCOUNTER_H_BASE + csr_addr_t'(i);
      localparam csr_addr_t A_MASK = CSR_MHPMEVENT_BASE     + csr_addr_t'(i);

      assign w_hit_lo[i]   = w_acc.en && (w_acc.addr == A_LO);
      assign w_hit_hi[i]   = w_acc.en && (w_acc.addr == A_HI);
      assign w_hit_mask[i] = w_acc.en && (w_acc.addr == A_MASK);
      assign w_cnt_ext[i]  = 64'(w_cnt[i]);

      ama_riscv_hpm_cnt #(
         .CNT_WIDTH  (CNT_WIDTH),
         .NUM_EVENTS (NUM_EVENTS)
      ) u_cnt (
         .clk        (clk),
         .rst        (rst),
         .i_events   (i_events),
         .i_inhibit  (w_inh_eff[i]),
         .i_wr_lo    (w_wr & w_hit_lo[i]),
         .i_wr_hi    (w_wr & w_hit_hi[i]),
         .i_wr_mask  (w_wr & w_hit_mask[i]),
         .i_wdata    (w_acc.wdata),
         .i_ovf_clr  (w_wr & w_hit_ovf & w_acc.wdata[MHPM_IDX_L+i]),
         .o_cnt      (w_cnt[i]),
         .o_mask     (w_mask[i]),
         .o_ovf      (w_ovf[i]),
         .o_ovf_next (w_ovf_next[i])
      );
   end

   always_comb begin
      w_rdata = '0;
      if (w_hit_inh) w_rdata = 32'({r_inhibit, {MHPM_IDX_L{1'b0}}});
      if (w_hit_ovf) w_rdata = 32'({w_ovf, {MHPM_IDX_L{1'b0}}});
      for (int i = 0; i < NUM_CNT; i++) begin
         if (w_hit_lo[i])   w_rdata = w_cnt_ext[i][31:0];
         if (w_hit_hi[i])   w_rdata = w_cnt_ext[i][63:32];
         if (w_hit_mask[i]) w_rdata = 32'(w_mask[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_inhibit <= '0;
         r_ovf_irq <= 1'b0;
      end else begin
         r_ovf_irq <= |w_ovf_next;
         if (w_wr && w_hit_inh) begin
            r_inhibit <= w_acc.wdata[MHPM_IDX_L +: NUM_CNT];
         end
      end
   end

   assign o_acc_rdata = w_rdata;
   assign o_acc_hit   = (|w_hit_lo) | (|w_hit_hi) | (|w_hit_mask) | w_hit_inh | w_hit_ovf;
   assign o_ovf_irq   = r_ovf_irq;

endmodule

// File: tb/tb_ama_riscv_hpm_unit.sv
// Directed bench for the HPM bank with an arithmetic reference model and per-cycle output comparison.
module tb_ama_riscv_hpm_unit;

   localparam int N  = 6;
   localparam int W  = 48;
   localparam int NE = 8;

   logic          clk;
   logic          rst;
   logic          acc_en;
   logic          acc_we;
   logic [11:0]   acc_addr;
   logic [31:0]   acc_wdata;
   logic [31:0]   o_acc_rdata;
   logic          o_acc_hit;
   logic [NE-1:0] events;
   logic          o_ovf_irq;

   int checks = 0;
   int errors = 0;
   bit cmp_on = 0;

   ama_riscv_hpm_unit #(.NUM_CNT(N), .CNT_WIDTH(W), .NUM_EVENTS(NE)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_acc_en    (acc_en),
      .i_acc_we    (acc_we),
      .i_acc_addr  (acc_addr),
      .i_acc_wdata (acc_wdata),
      .o_acc_rdata (o_acc_rdata),
      .o_acc_hit   (o_acc_hit),
      .i_events    (events),
      .o_ovf_irq   (o_ovf_irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: counters as plain integers, mod 2^W arithmetic
   logic [63:0]  m_cnt  [N];
   logic [31:0]  m_mask [N];
   logic [N-1:0] m_inh;
   logic [N-1:0] m_ovf;
   logic         m_irq;
   logic [N-1:0] m_ovf_n;
   logic [64:0]  m_sum;
   bit           m_wr;
   bit           m_frozen;
   bit           m_wrap;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            m_cnt[i]  = 64'd0;
            m_mask[i] = 32'd0;
         end
         m_inh = '0;
         m_ovf = '0;
         m_irq = 1'b0;
      end else begin
         m_wr     = acc_en && acc_we;
         m_frozen = 1'b0;
`ifdef AMA_RISCV_HPM_FREEZE_ON_OVF_EN
         m_frozen = (m_ovf != '0);
`endif
         for (int i = 0; i < N; i++) begin
            m_wrap = 1'b0;
            if (m_wr && acc_addr == 12'hB03 + i) begin
               m_cnt[i] = {m_cnt[i][63:32], acc_wdata};
            end else if (m_wr && acc_addr == 12'hB83 + i) begin
               m_cnt[i] = (m_cnt[i] & 64'hFFFF_FFFF) |
                          ((64'(acc_wdata) & ((64'd1 << (W - 32)) - 64'd1)) << 32);
            end else if (!m_inh[i] && !m_frozen) begin
               m_sum = 65'(m_cnt[i]) + 65'($countones(events & m_mask[i][NE-1:0]));
               if (m_sum >= (65'd1 << W)) begin
                  m_wrap = 1'b1;
                  m_sum  = m_sum - (65'd1 << W);
               end
               m_cnt[i] = m_sum[63:0];
            end
            m_ovf_n[i] = m_wrap || (m_ovf[i] && !(m_wr && acc_addr == 12'h7C0 && acc_wdata[3 + i]));
         end
         for (int i = 0; i < N; i++) begin
            if (m_wr && acc_addr == 12'h323 + i) m_mask[i] = acc_wdata & ((32'd1 << NE) - 32'd1);
         end
         if (m_wr && acc_addr == 12'h320) m_inh = acc_wdata[3 +: N];
         m_ovf = m_ovf_n;
         m_irq = |m_ovf_n;
      end
   end

   function automatic logic [32:0] m_rd(logic [11:0] a);
      if (a == 12'h320) return {1'b1, 32'(m_inh) << 3};
      if (a == 12'h7C0) return {1'b1, 32'(m_ovf) << 3};
      for (int i = 0; i < N; i++) begin
         if (a == 12'hB03 + i) return {1'b1, m_cnt[i][31:0]};
         if (a == 12'hB83 + i) return {1'b1, m_cnt[i][63:32]};
         if (a == 12'h323 + i) return {1'b1, m_mask[i]};
      end
      return 33'd0;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
      end
   endtask

   logic [32:0] cmp_exp;
   always @(negedge clk) begin
      if (cmp_on) begin
         cmp_exp = acc_en ? m_rd(acc_addr) : 33'd0;
         chk("model_hit", 32'(o_acc_hit), 32'(cmp_exp[32]));
         chk("model_rdata", o_acc_rdata, cmp_exp[31:0]);
         chk("model_irq", 32'(o_ovf_irq), 32'(m_irq));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic csr_wr(logic [11:0] a, logic [31:0] d);
      acc_en = 1'b1; acc_we = 1'b1; acc_addr = a; acc_wdata = d;
      tick();
      acc_en = 1'b0; acc_we = 1'b0;
   endtask

   task automatic rd(logic [11:0] a, logic [31:0] exp, string name);
      acc_en = 1'b1; acc_we = 1'b0; acc_addr = a;
      @(negedge clk);
      chk(name, o_acc_rdata, exp);
      tick();
      acc_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; acc_en = 1'b0; acc_we = 1'b0; acc_addr = '0; acc_wdata = '0; events = '0;
      tick();
      cmp_on = 1'b1;
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_irq", 32'(o_ovf_irq), 32'd0);
      for (int i = 0; i < N; i++) begin
         rd(12'hB03 + 12'(i), 32'd0, "rst_cnt_lo");
         rd(12'hB83 + 12'(i), 32'd0, "rst_cnt_hi");
         rd(12'h323 + 12'(i), 32'd0, "rst_mask");
      end
      rd(12'h320, 32'd0, "rst_inhibit");
      rd(12'h7C0, 32'd0, "rst_ovf");

      // Out-of-range index: no hit, write ignored
      csr_wr(12'hB09, 32'h1234_5678);
      acc_en = 1'b1; acc_we = 1'b0; acc_addr = 12'hB09;
      @(negedge clk);
      chk("unmapped_hit", 32'(o_acc_hit), 32'd0);
      chk("unmapped_rdata", o_acc_rdata, 32'd0);
      tick();
      acc_en = 1'b0;

      // Popcount counting, mask truncation
      csr_wr(12'h323, 32'hFFFF_FF05);
      rd(12'h323, 32'h0000_0005, "mask_trunc");
      events = 8'h07;
      repeat (10) tick();
      events = 8'h00;
      rd(12'hB03, 32'd20, "ctr3_popcount");
      rd(12'hB04, 32'd0, "ctr4_mask0");

      // Wrap of the last counter (mhpmcounter8)
      csr_wr(12'hB08, 32'hFFFF_FFFE);
      csr_wr(12'hB88, 32'hFFFF_FFFF);
      csr_wr(12'h328, 32'h0000_0001);
      rd(12'hB88, 32'h0000_FFFF, "hi_write_trunc");
      events = 8'h01;
      tick();
      chk("irq_before_wrap", 32'(o_ovf_irq), 32'd0);
      tick();
      chk("irq_after_wrap", 32'(o_ovf_irq), 32'd1);
      tick();
      events = 8'h00;
      rd(12'hB08, 32'd1, "wrap_lo");
      rd(12'hB88, 32'd0, "wrap_hi");
      rd(12'h7C0, 32'h0000_0100, "ovf_bit8");
      rd(12'hB03, 32'd23, "ctr3_after_wrap_phase");

      // Second wrap collides with W1C: set wins
      csr_wr(12'hB08, 32'hFFFF_FFFF);
      csr_wr(12'hB88, 32'h0000_FFFF);
      events = 8'h01;
      csr_wr(12'h7C0, 32'h0000_0100);
      events = 8'h00;
      rd(12'h7C0, 32'h0000_0100, "ovf_set_wins");
      rd(12'hB08, 32'd0, "second_wrap_lo");
      csr_wr(12'h7C0, 32'h0000_0100);
      chk("irq_after_clear", 32'(o_ovf_irq), 32'd0);
      rd(12'h7C0, 32'd0, "ovf_cleared");

      // Inhibit
      csr_wr(12'h320, 32'hFFFF_FFFF);
      rd(12'h320, 32'h0000_01F8, "inhibit_writable_bits");
      csr_wr(12'h320, 32'h0000_0008);
      events = 8'h05;
      csr_wr(12'hB03, 32'h0000_0010);
      tick();
      rd(12'hB03, 32'h0000_0010, "inhibit_hold");
      csr_wr(12'h320, 32'h0000_0000);
      tick();
      events = 8'h00;
      rd(12'hB03, 32'h0000_0012, "inhibit_resume");

      // Overflow of ctr3 while ctr4 counts
      csr_wr(12'h324, 32'h0000_0002);
      csr_wr(12'hB03, 32'hFFFF_FFFF);
      csr_wr(12'hB83, 32'h0000_FFFF);
      events = 8'h03;
      repeat (4) tick();
      events = 8'h00;
`ifdef AMA_RISCV_HPM_FREEZE_ON_OVF_EN
      rd(12'hB04, 32'd1, "freeze_ctr4");
      rd(12'hB03, 32'd0, "freeze_ctr3");
`else
      rd(12'hB04, 32'd4, "nofreeze_ctr4");
      rd(12'hB03, 32'd3, "nofreeze_ctr3");
`endif
      csr_wr(12'h7C0, 32'h0000_0008);
      events = 8'h02;
      repeat (2) tick();
      events = 8'h00;
`ifdef AMA_RISCV_HPM_FREEZE_ON_OVF_EN
      rd(12'hB04, 32'd3, "freeze_resume_ctr4");
`else
      rd(12'hB04, 32'd6, "nofreeze_ctr4_late");
`endif

      // Reset mid-count discards that cycle's events
      events = 8'h07;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      events = 8'h00;
      chk("midrst_irq", 32'(o_ovf_irq), 32'd0);
      rd(12'hB03, 32'd0, "midrst_ctr3");
      rd(12'h323, 32'd0, "midrst_mask");
      rd(12'h7C0, 32'd0, "midrst_ovf");

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
